// File: rtl/event_readout_if.sv
// Byte stream from the event readout engine to the host-side transmitter.
// A byte moves when out_valid && out_ready on a rising clock edge.
interface event_readout_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/event_readout.sv
// Streams a completed event out of the circular sample RAM: one channel at a time,
// starting pre_offset samples before the trigger address, one byte per RAM read.
module event_readout #(
  parameter int RAM_WIDTH   = 10,
  parameter int NCHAN       = 4,
  parameter int RAM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   data_ready,
  input  logic [RAM_WIDTH-1:0]   trig_wraddr,
  input  logic [RAM_WIDTH-1:0]   pre_offset,
  input  logic [RAM_WIDTH:0]     nsamples,
  input  logic [NCHAN-1:0]       chan_mask,
  output logic                   rden,
  output logic [RAM_WIDTH-1:0]   rdaddress,
  input  logic [NCHAN*8-1:0]     ram_q,
  event_readout_if.master        out_if,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [RAM_WIDTH:0]   MAX_NS  = {1'b1, {RAM_WIDTH{1'b0}}};
  localparam logic [RAM_WIDTH:0]   CNT_ONE = {{RAM_WIDTH{1'b0}}, 1'b1};
  localparam logic [RAM_WIDTH-1:0] ADR_ONE = {{(RAM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]        LAT_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]        LAT_END = LW'(RAM_LATENCY - 1);
  localparam logic [CW:0]          CH_ONE  = {{CW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [RAM_WIDTH-1:0] trig_r, trig_s, pre_r, pre_s;
  logic [RAM_WIDTH-1:0] base_r, base_s, addr_r, addr_s;
  logic [RAM_WIDTH:0]   nsamp_r, nsamp_s, cnt_r, cnt_s, cnt_inc_s;
  logic [NCHAN-1:0]     mask_r, mask_s;
  logic [CW-1:0]        chan_r, chan_s;
  logic [LW-1:0]        lat_r, lat_s;
  logic                 rden_r, rden_s, busy_r, busy_s, done_r, done_s;
  logic [RAM_WIDTH-1:0] rdaddr_r, rdaddr_s;
  logic [7:0]           data_r, data_s;
  logic                 valid_r, valid_s;
  logic [CW:0]          pick_s;

  // {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CW:0] find_chan(input logic [NCHAN-1:0] m, input logic [CW:0] from);
    logic [CW:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      r = (m[i] && ((CW+1)'(i) >= from)) ? {1'b1, CW'(i)} : r;
    end
    return r;
  endfunction

  // Next-state and next-output logic for the readout sequencer.
  always_comb begin
    state_s   = state_r;
    trig_s    = trig_r;
    pre_s     = pre_r;
    nsamp_s   = nsamp_r;
    mask_s    = mask_r;
    base_s    = base_r;
    addr_s    = addr_r;
    cnt_s     = cnt_r;
    chan_s    = chan_r;
    lat_s     = lat_r;
    data_s    = data_r;
    valid_s   = valid_r;
    pick_s    = '0;
    cnt_inc_s = cnt_r + CNT_ONE;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          trig_s  = trig_wraddr;
          pre_s   = pre_offset;
          nsamp_s = (nsamples > MAX_NS) ? MAX_NS : nsamples;
          mask_s  = chan_mask;
          state_s = S_ARM;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARM: begin
        pick_s = find_chan(mask_r, '0);
        if (!data_ready) begin
          state_s = S_ARM;
        end else if ((nsamp_r == '0) || !pick_s[CW]) begin
          state_s = S_DONE;
        end else begin
          chan_s  = pick_s[CW-1:0];
          base_s  = trig_r - pre_r;
          addr_s  = trig_r - pre_r;
          cnt_s   = '0;
          state_s = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_s   = '0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (lat_r == LAT_END) begin
          data_s  = ram_q[{chan_r, 3'b000} +: 8];
          valid_s = 1'b1;
          state_s = S_SEND;
        end else begin
          lat_s   = lat_r + LAT_ONE;
        end
      end
      S_SEND: begin
        pick_s = find_chan(mask_r, {1'b0, chan_r} + CH_ONE);
        if (!out_if.out_ready) begin
          state_s = S_SEND;
        end else if (cnt_inc_s < nsamp_r) begin
          valid_s = 1'b0;
          cnt_s   = cnt_inc_s;
          addr_s  = addr_r + ADR_ONE;
          state_s = S_ISSUE;
        end else if (pick_s[CW]) begin
          // Next channel restarts at the same base address.
          valid_s = 1'b0;
          chan_s  = pick_s[CW-1:0];
          cnt_s   = '0;
          addr_s  = base_r;
          state_s = S_ISSUE;
        end else begin
          valid_s = 1'b0;
          state_s = S_DONE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    rden_s   = (state_s == S_ISSUE);
    rdaddr_s = rden_s ? addr_s : rdaddr_r;
    busy_s   = (state_s != S_IDLE);
    done_s   = (state_s == S_DONE);
  end

  // State and registered outputs; reset abandons any event in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      trig_r   <= '0;
      pre_r    <= '0;
      nsamp_r  <= '0;
      mask_r   <= '0;
      base_r   <= '0;
      addr_r   <= '0;
      cnt_r    <= '0;
      chan_r   <= '0;
      lat_r    <= '0;
      data_r   <= 8'h00;
      valid_r  <= 1'b0;
      rden_r   <= 1'b0;
      rdaddr_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      trig_r   <= trig_s;
      pre_r    <= pre_s;
      nsamp_r  <= nsamp_s;
      mask_r   <= mask_s;
      base_r   <= base_s;
      addr_r   <= addr_s;
      cnt_r    <= cnt_s;
      chan_r   <= chan_s;
      lat_r    <= lat_s;
      data_r   <= data_s;
      valid_r  <= valid_s;
      rden_r   <= rden_s;
      rdaddr_r <= rdaddr_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign rden             = rden_r;
  assign rdaddress        = rdaddr_r;
  assign out_if.out_data  = data_r;
  assign out_if.out_valid = valid_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_event_readout.sv
// Directed bench for event_readout: latency-2 RAM model (q = addr + 16*ch per lane),
// expected bytes queued at stimulus time and checked by an independent output monitor.
module tb_event_readout;
  localparam int RW  = 10;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset, start, data_ready;
  logic [RW-1:0]   trig_wraddr, pre_offset;
  logic [RW:0]     nsamples;
  logic [NC-1:0]   chan_mask;
  logic            rden, busy, done;
  logic [RW-1:0]   rdaddress;
  logic [NC*8-1:0] ram_q;

  event_readout_if sif();

  event_readout #(.RAM_WIDTH(RW), .NCHAN(NC), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .data_ready(data_ready),
    .trig_wraddr(trig_wraddr), .pre_offset(pre_offset), .nsamples(nsamples),
    .chan_mask(chan_mask), .rden(rden), .rdaddress(rdaddress), .ram_q(ram_q),
    .out_if(sif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data only valid exactly LAT cycles after a rden cycle.
  function automatic logic [NC*8-1:0] ram_word(input logic [RW-1:0] a);
    logic [NC*8-1:0] w;
    for (int c = 0; c < NC; c++) w[c*8 +: 8] = 8'(a + RW'(16 * c));
    return w;
  endfunction

  logic [RW-1:0] p1;
  logic          v1;
  always @(posedge clk) begin
    v1    <= rden;
    p1    <= rdaddress;
    ram_q <= v1 ? ram_word(p1) : {NC{8'hEE}};
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int n_acc, rden_cnt, done_cnt, done_cyc;
  int acc_cyc[$];
  logic [RW-1:0] rd_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Output monitor: scoreboard pop on accept, hold-stability, done/rden bookkeeping.
  initial begin
    logic       hold_v;
    logic [7:0] hold_d;
    hold_v = 1'b0;
    hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", 32'(sif.out_valid), 32'd1);
          chk("hold_data", 32'(sif.out_data), 32'(hold_d));
        end
        if (sif.out_valid && sif.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", 32'(sif.out_data), 32'hFFFF_FFFF);
          else chk("byte", 32'(sif.out_data), 32'(exp_q.pop_front()));
          n_acc++;
          acc_cyc.push_back(cyc);
        end
        hold_v = sif.out_valid && !sif.out_ready;
        hold_d = sif.out_data;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (rden) begin
          rden_cnt++;
          rd_log.push_back(rdaddress);
        end
      end
    end
  end

  task automatic start_event(input logic [RW-1:0] t, input logic [RW-1:0] p,
                             input logic [RW:0] ns, input logic [NC-1:0] m);
    n_acc = 0; rden_cnt = 0; done_cnt = 0; done_cyc = 0;
    acc_cyc.delete(); rd_log.delete();
    @(posedge clk); #1;
    trig_wraddr = t; pre_offset = p; nsamples = ns; chan_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    trig_wraddr = ~t; pre_offset = ~p; nsamples = ~ns; chan_mask = ~m;
  endtask

  task automatic wait_done(input string nm, input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rnd) sif.out_ready = 1'($urandom_range(0, 1));
    end
    sif.out_ready = 1'b1;
    chk({nm, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_ready = 1'b1;
    trig_wraddr = '0; pre_offset = '0; nsamples = '0; chan_mask = '0;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_rdaddress", 32'(rdaddress), 32'd0);
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_data", 32'(sif.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: basic single channel, throughput and done timing
    exp_q = '{8'd90, 8'd91, 8'd92, 8'd93};
    start_event(10'd100, 10'd10, 11'd4, 4'b0001);
    wait_done("t1", 200, 1'b0);
    chk("t1_bytes", 32'(n_acc), 32'd4);
    chk("t1_rden_pulses", 32'(rden_cnt), 32'd4);
    chk("t1_done_after_last", 32'(done_cyc), 32'(acc_cyc[3] + 1));
    for (int i = 1; i < 4; i++) chk("t1_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(LAT + 2));

    // 2: address wrap
    exp_q = '{8'd254, 8'd255, 8'd0, 8'd1};
    start_event(10'd3, 10'd5, 11'd4, 4'b0001);
    wait_done("t2", 200, 1'b0);
    chk("t2_addr0", 32'(rd_log[0]), 32'd1022);
    chk("t2_addr1", 32'(rd_log[1]), 32'd1023);
    chk("t2_addr2", 32'(rd_log[2]), 32'd0);
    chk("t2_addr3", 32'(rd_log[3]), 32'd1);

    // 3: sparse mask, each channel restarts at base
    exp_q = '{8'd36, 8'd37, 8'd68, 8'd69};
    start_event(10'd25, 10'd5, 11'd2, 4'b1010);
    wait_done("t3", 200, 1'b0);
    chk("t3_bytes", 32'(n_acc), 32'd4);

    // 4: all channels, 64 samples, random backpressure
    for (int ch = 0; ch < 4; ch++)
      for (int k = 0; k < 64; k++) exp_q.push_back(8'(470 + k + 16 * ch));
    start_event(10'd500, 10'd30, 11'd64, 4'b1111);
    wait_done("t4", 10000, 1'b1);
    chk("t4_bytes", 32'(n_acc), 32'd256);

    // 5: wait for data_ready, then empty events
    data_ready = 1'b0;
    exp_q = '{8'd42, 8'd43};
    start_event(10'd10, 10'd0, 11'd2, 4'b0100);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_waiting", 32'(busy), 32'd1);
    chk("t5_no_rden", 32'(rden_cnt), 32'd0);
    @(posedge clk); #1 data_ready = 1'b1;
    wait_done("t5a", 200, 1'b0);
    chk("t5a_bytes", 32'(n_acc), 32'd2);
    start_event(10'd10, 10'd0, 11'd0, 4'b1111);
    wait_done("t5b", 50, 1'b0);
    chk("t5b_bytes", 32'(n_acc), 32'd0);
    chk("t5b_rden", 32'(rden_cnt), 32'd0);
    start_event(10'd10, 10'd0, 11'd5, 4'b0000);
    wait_done("t5c", 50, 1'b0);
    chk("t5c_bytes", 32'(n_acc), 32'd0);

    // 6: reset while a byte is waiting in SEND
    sif.out_ready = 1'b0;
    start_event(10'd100, 10'd10, 11'd64, 4'b1111);
    for (int i = 0; i < 50 && !sif.out_valid; i++) @(negedge clk);
    chk("t6_valid_seen", 32'(sif.out_valid), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", 32'(sif.out_valid), 32'd0);
    chk("t6_rst_rden", 32'(rden), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    sif.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    exp_q = '{8'd90, 8'd91, 8'd92, 8'd93};
    start_event(10'd100, 10'd10, 11'd4, 4'b0001);
    wait_done("t6", 200, 1'b0);
    chk("t6_bytes", 32'(n_acc), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
